// File: rtl/trace_pkg.sv
// Shared types and defaults for the writeback trace buffer.
package trace_pkg;

    localparam int TRACE_DEPTH  = 16;
    localparam int TRACE_DATA_W = 32;
    localparam int TRACE_ADDR_W = 4;
    localparam int TRACE_TS_W   = 16;

    localparam logic [7:0] DROP_MAX = 8'd255;

    typedef struct packed {
        logic [TRACE_TS_W-1:0]   ts;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] data;
    } trace_entry_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous FIFO of trace entries; a push on full is accepted only when a pop frees a slot in the same cycle.
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH = TRACE_DEPTH,
    parameter type T     = trace_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push,
    input  T                       i_data,
    input  logic                   i_pop,
    output T                       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T               r_mem [DEPTH];
    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           w_pop_ok;
    logic           w_push_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_pop_ok  = i_pop && !o_empty;
    assign w_push_ok = i_push && (!o_full || w_pop_ok);

    // Head is forced to zero when empty so stale storage never shows on the port.
    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/wb_trace_buffer.sv
// Timestamped capture of register-file writebacks into a FIFO drained over valid/ready, with sticky drop accounting.
module wb_trace_buffer
    import trace_pkg::*;
#(
    parameter int DEPTH  = TRACE_DEPTH,
    parameter int DATA_W = TRACE_DATA_W,
    parameter int ADDR_W = TRACE_ADDR_W,
    parameter int TS_W   = TRACE_TS_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   trace_en,
    input  logic                   RegWrite,
    input  logic [ADDR_W-1:0]      A3,
    input  logic [DATA_W-1:0]      WD3,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TS_W-1:0]        out_ts,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic [7:0]             drop_cnt,
    input  logic                   clear_ovf
);

    typedef struct packed {
        logic [TS_W-1:0]   ts;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [TS_W-1:0] r_ts;
    logic            r_overflow;
    logic [7:0]      r_drop_cnt;
    entry_t          w_wr_entry;
    entry_t          w_head;
    logic            w_capture;
    logic            w_full;
    logic            w_empty;
    logic            w_drop;

    assign w_capture  = RegWrite && trace_en;
    assign w_wr_entry = '{ts: r_ts, addr: A3, data: WD3};
    // When full the FIFO is non-empty, so out_ready alone means a slot frees up this edge.
    assign w_drop     = w_capture && w_full && !out_ready;

    trace_fifo #(
        .DEPTH (DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_capture),
        .i_data  (w_wr_entry),
        .i_pop   (out_ready),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // A drop in the same cycle as a clear restarts the tally at one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            r_drop_cnt <= clear_ovf ? 8'd1 : sat_inc8(r_drop_cnt);
        end else if (clear_ovf) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_valid = !w_empty;
    assign out_ts    = w_head.ts;
    assign out_addr  = w_head.addr;
    assign out_data  = w_head.data;
    assign overflow  = r_overflow;
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed bench for wb_trace_buffer with a scoreboard queue and a drop/overflow reference model.
module tb_wb_trace_buffer;
    import trace_pkg::*;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset;
    logic        trace_en;
    logic        RegWrite;
    logic [3:0]  A3;
    logic [31:0] WD3;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_ts;
    logic [3:0]  out_addr;
    logic [31:0] out_data;
    logic [4:0]  count;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clear_ovf;

    int checks = 0;
    int errors = 0;

    trace_entry_t sb[$];
    logic [15:0]  ts_model;
    int           exp_drop;
    logic         exp_ovf;

    wb_trace_buffer #(
        .DEPTH  (16),
        .DATA_W (32),
        .ADDR_W (4),
        .TS_W   (16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .trace_en  (trace_en),
        .RegWrite  (RegWrite),
        .A3        (A3),
        .WD3       (WD3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
        .out_addr  (out_addr),
        .out_data  (out_data),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .clear_ovf (clear_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge reset) begin
        if (!reset) ts_model <= 16'd0;
        else        ts_model <= ts_model + 16'd1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_count"},    32'(count),     32'(sb.size()));
        chk({tag, "_valid"},    32'(out_valid), 32'(sb.size() != 0));
        chk({tag, "_overflow"}, 32'(overflow),  32'(exp_ovf));
        chk({tag, "_drop_cnt"}, 32'(drop_cnt),  32'(exp_drop));
    endtask

    // One cycle of stimulus: compare/pop the head if reading, then model the push or drop.
    task automatic drive(input logic we, input logic [3:0] a, input logic [31:0] d,
                         input logic rdy, input logic clr);
        trace_entry_t e;
        logic         drop;
        RegWrite  = we;
        A3        = a;
        WD3       = d;
        out_ready = rdy;
        clear_ovf = clr;
        if (rdy && sb.size() > 0) begin
            e = sb.pop_front();
            chk("head_valid", 32'(out_valid), 32'd1);
            chk("head_ts",    32'(out_ts),    32'(e.ts));
            chk("head_addr",  32'(out_addr),  32'(e.addr));
            chk("head_data",  out_data,       e.data);
        end
        drop = 1'b0;
        if (we && trace_en) begin
            if (sb.size() < DEPTH) sb.push_back('{ts: ts_model, addr: a, data: d});
            else                   drop = 1'b1;
        end
        if (drop) begin
            exp_ovf  = 1'b1;
            exp_drop = clr ? 1 : ((exp_drop < 255) ? exp_drop + 1 : 255);
        end else if (clr) begin
            exp_ovf  = 1'b0;
            exp_drop = 0;
        end
        step();
        RegWrite  = 1'b0;
        out_ready = 1'b0;
        clear_ovf = 1'b0;
    endtask

    initial begin
        reset = 1'b0; trace_en = 1'b0; RegWrite = 1'b0; A3 = '0; WD3 = '0;
        out_ready = 1'b0; clear_ovf = 1'b0; exp_drop = 0; exp_ovf = 1'b0;

        step(); step(); step();
        chk("rst_valid",    32'(out_valid), 32'd0);
        chk("rst_count",    32'(count),     32'd0);
        chk("rst_ts",       32'(out_ts),    32'd0);
        chk("rst_addr",     32'(out_addr),  32'd0);
        chk("rst_data",     out_data,       32'd0);
        chk("rst_overflow", 32'(overflow),  32'd0);
        chk("rst_drop",     32'(drop_cnt),  32'd0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        chk_state("idle");

        // Single capture at timestamp 12.
        trace_en = 1'b1;
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 32'h0000_0007, 1'b0, 1'b0);
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_addr",  32'(out_addr),  32'd3);
        chk("one_data",  out_data,       32'd7);
        chk("one_ts",    32'(out_ts),    32'd12);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("one_popped");

        // 18 writes into a 16-deep FIFO.
        for (int i = 0; i < 18; i++) drive(1'b1, 4'(i), $urandom, 1'b0, 1'b0);
        chk("burst_count", 32'(count),    32'd16);
        chk("burst_ovf",   32'(overflow), 32'd1);
        chk("burst_drop",  32'(drop_cnt), 32'd2);
        chk_state("burst");
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("burst_drained");
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("underflow");

        // Push on full with a simultaneous pop.
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(15 - i), $urandom, 1'b0, 1'b0);
        chk("full_count", 32'(count), 32'd16);
        drive(1'b1, 4'hA, 32'hCAFE_F00D, 1'b1, 1'b0);
        chk("fullpop_count", 32'(count),    32'd16);
        chk("fullpop_drop",  32'(drop_cnt), 32'd2);
        chk_state("fullpop");
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("fullpop_drained");

        // Drop saturation and clear behaviour.
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), $urandom, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        chk("clr0_ovf",  32'(overflow), 32'd0);
        chk("clr0_drop", 32'(drop_cnt), 32'd0);
        for (int i = 0; i < 300; i++) drive(1'b1, 4'(i), $urandom, 1'b0, 1'b0);
        chk("sat_drop", 32'(drop_cnt), 32'd255);
        chk("sat_ovf",  32'(overflow), 32'd1);
        chk_state("sat");
        drive(1'b0, 4'd0, 32'd0, 1'b0, 1'b1);
        chk("clr_ovf",  32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_cnt), 32'd0);
        drive(1'b1, 4'd1, 32'h5555_AAAA, 1'b0, 1'b1);
        chk("clrdrop_drop", 32'(drop_cnt), 32'd1);
        chk("clrdrop_ovf",  32'(overflow), 32'd1);
        chk_state("clrdrop");
        for (int i = 0; i < 16; i++) drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("sat_drained");

        // Asynchronous reset with entries queued.
        for (int i = 0; i < 5; i++) drive(1'b1, 4'(i + 2), $urandom, 1'b0, 1'b0);
        chk("pre_rst_count", 32'(count), 32'd5);
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_valid",    32'(out_valid), 32'd0);
        chk("arst_count",    32'(count),     32'd0);
        chk("arst_data",     out_data,       32'd0);
        chk("arst_overflow", 32'(overflow),  32'd0);
        chk("arst_drop",     32'(drop_cnt),  32'd0);
        sb.delete();
        exp_drop = 0;
        exp_ovf  = 1'b0;
        step(); step();
        reset = 1'b1;

        trace_en = 1'b0;
        for (int i = 0; i < 3; i++) drive(1'b1, 4'd5, $urandom, 1'b0, 1'b0);
        chk_state("disabled");
        trace_en = 1'b1;
        drive(1'b1, 4'h9, 32'h0000_1234, 1'b0, 1'b0);
        chk("restart_ts",   32'(out_ts),   32'd3);
        chk("restart_data", out_data,      32'h0000_1234);
        drive(1'b0, 4'd0, 32'd0, 1'b1, 1'b0);
        chk_state("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
